// File: rtl/timebase_ctrl.sv
// Watch timebase: 50 MHz prescaler producing 1 kHz / 1 Hz enable strobes,
// with run/pause and a valid/ready port for run-time ratio changes.
module timebase_ctrl #(
    parameter int CNT_W       = 17,
    parameter int DIV_DEFAULT = 50000,
    parameter int MS_PER_S    = 1000
) (
    input  logic             clk_50Mhz,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick_1khz,
    output logic             tick_1hz,
    output logic [9:0]       ms_count,
    output logic [CNT_W-1:0] div_active
);

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] presc, presc_nxt;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] pend_div, pend_nxt;
    logic [9:0]       ms_nxt;
    logic             tick_nxt;
    logic             hz_nxt;
    logic             err_nxt;
    logic             ready_nxt;
    logic             adv;
    logic             xfer;
    logic             legal;
    logic             terminal;

    assign xfer     = cfg_valid && cfg_ready;
    assign legal    = cfg_div >= CNT_W'(2);
    assign terminal = presc == div_active - CNT_W'(1);

    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            state      <= STOP;
            presc      <= '0;
            ms_count   <= '0;
            div_active <= CNT_W'(DIV_DEFAULT);
            pend_div   <= '0;
            tick_1khz  <= 1'b0;
            tick_1hz   <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_ready  <= 1'b1;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            ms_count   <= ms_nxt;
            div_active <= div_nxt;
            pend_div   <= pend_nxt;
            tick_1khz  <= tick_nxt;
            tick_1hz   <= hz_nxt;
            cfg_err    <= err_nxt;
            cfg_ready  <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        ms_nxt    = ms_count;
        div_nxt   = div_active;
        pend_nxt  = pend_div;
        tick_nxt  = 1'b0;
        hz_nxt    = 1'b0;
        err_nxt   = xfer && !legal;
        adv       = 1'b0;

        unique case (state)
            STOP: begin
                if (xfer && legal) begin
                    div_nxt   = cfg_div;
                    presc_nxt = '0;
                    if (run) state_nxt = RUN;
                end else if (run) begin
                    state_nxt = RUN;
                    adv       = 1'b1;
                end
            end
            RUN: begin
                if (!run) begin
                    // Pausing suppresses any terminal count this cycle
                    state_nxt = STOP;
                    if (xfer && legal) begin
                        div_nxt   = cfg_div;
                        presc_nxt = '0;
                    end
                end else begin
                    adv = 1'b1;
                    if (xfer && legal) begin
                        pend_nxt  = cfg_div;
                        state_nxt = PEND;
                    end
                end
            end
            PEND: begin
                if (!run) begin
                    state_nxt = STOP;
                    div_nxt   = pend_div;
                    presc_nxt = '0;
                end else begin
                    adv = 1'b1;
                    if (terminal) begin
                        div_nxt   = pend_div;
                        state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = STOP;
        endcase

        if (adv) begin
            if (terminal) begin
                presc_nxt = '0;
                tick_nxt  = 1'b1;
                if (ms_count == 10'(MS_PER_S - 1)) begin
                    ms_nxt = '0;
                    hz_nxt = 1'b1;
                end else begin
                    ms_nxt = ms_count + 10'd1;
                end
            end else begin
                presc_nxt = presc + CNT_W'(1);
            end
        end

        ready_nxt = state_nxt != PEND;
    end

endmodule

// File: doc/timebase_ctrl.md
# timebase_ctrl

Timebase controller for the digital watch: owns the 50 MHz prescaler and turns it into single-cycle enable strobes (1 kHz, 1 Hz) for display scan, debounce and timekeeping logic. Supports run/pause and a valid/ready handshake that reconfigures the division ratio at run time. New ratios are applied only on a tick boundary, so downstream logic never sees a short or runt tick. All downstream blocks run on `clk_50Mhz` and use these strobes as clock enables; no derived clocks.

## Interface

Parameters:
- `CNT_W`, 17: prescaler and ratio width.
- `DIV_DEFAULT`, 50000: reset ratio, in `clk_50Mhz` cycles per 1 kHz tick.
- `MS_PER_S`, 1000: 1 kHz ticks per 1 Hz tick; must be ≥2.

Ports:
- `clk_50Mhz`  in  1: sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `run`  in  1: 1 means count; 0 means pause (counters hold).
- `cfg_valid`  in  1: new ratio offered.
- `cfg_div`  in  CNT_W: offered ratio; legal range is 2 to 2^CNT_W−1.
- `cfg_ready`  out  1: controller can accept a ratio.
- `cfg_err`  out  1: one-cycle pulse when an accepted ratio is illegal.
- `tick_1khz`  out  1: one-cycle enable strobe.
- `tick_1hz`  out  1: one-cycle enable strobe, coincident with a `tick_1khz`.
- `ms_count`  out  10: current 1 kHz tick index, 0 to MS_PER_S−1.
- `div_active`  out  CNT_W: ratio currently in force.

## Operation

- States:
  - STOP: `run`=0, no pending ratio.
  - RUN: `run`=1, no pending ratio.
  - PEND: `run`=1, ratio pending.
- Reset values:
  - state STOP, prescaler 0, `ms_count` 0.
  - `div_active` = DIV_DEFAULT, pending register 0.
  - `tick_1khz`, `tick_1hz`, `cfg_err` = 0; `cfg_ready` = 1.
- Prescaler (RUN or PEND only):
  - Counts 0 to `div_active`−1.
  - At terminal count (`div_active`−1): prescaler ← 0, `tick_1khz` ← 1 for the next cycle.
  - `ms_count` increments on that same edge and wraps from MS_PER_S−1 to 0.
  - The wrap edge also sets `tick_1hz` ← 1 for one cycle.
- STOP:
  - Prescaler and `ms_count` hold their values; no ticks.
  - On `run`=1, go to RUN and resume from the held count.
- Handshake:
  - Transfer occurs when `cfg_valid` && `cfg_ready`.
  - `cfg_ready` = 1 in STOP and RUN, 0 in PEND.
  - `cfg_div` is sampled only on a transfer.
- Illegal ratio (`cfg_div` < 2):
  - Next cycle: `cfg_err` = 1 for one cycle.
  - No state change, `div_active` unchanged.
- Legal ratio accepted in STOP:
  - Next cycle: `div_active` ← `cfg_div`, prescaler ← 0.
  - `ms_count` is unchanged.
- Legal ratio accepted in RUN:
  - Store in the pending register and go to PEND.
  - The terminal count that follows the acceptance edge applies it: `div_active` ← pending, prescaler ← 0, tick still emitted, return to RUN.
  - If acceptance happens on a terminal-count cycle, that tick uses the old ratio; the new ratio applies at the following terminal count.
- `run` falls in PEND:
  - Go to STOP and apply the pending ratio immediately.
  - Prescaler ← 0, no tick.
- `run` falls in RUN:
  - Go to STOP.
  - A terminal count on that same cycle is suppressed: no tick, prescaler holds.
- `rst` has priority over everything.
  - Reset mid-PEND discards the pending ratio.
  - A tick in flight is cleared.

## Timing

- All outputs are registered; no combinational input-to-output paths.
- Tick latency and period:
  - With `run` held at 1 from cycle 0 (first edge sampling `run`=1), `tick_1khz` is high in cycle `div_active`.
  - After that, the tick period is exactly `div_active` cycles.
- `tick_1hz` period is `div_active`×MS_PER_S cycles.
- `cfg_ready` falls one cycle after a RUN-state transfer.
  - It rises in the cycle after the applying terminal count.
  - Max wait is `div_active`+1 cycles.
- `div_active` updates on the same edge that asserts the boundary `tick_1khz`.
- `cfg_err` is high for exactly one cycle, one cycle after the transfer.

## Test plan

All scenarios use CNT_W=8, DIV_DEFAULT=4, MS_PER_S=5.

- Reset, then `run`=1 held:
  - `tick_1khz` high at cycles 4, 8, 12, …
  - `ms_count` steps 1,2,3,4,0.
  - `tick_1hz` high only at cycle 20, coincident with `tick_1khz`.
- `run`=0 for 7 cycles while prescaler = 2, then `run`=1:
  - No ticks during the pause, `ms_count` held.
  - Next tick lands 2 cycles after resume.
- In RUN, transfer `cfg_div`=6 while prescaler = 1:
  - `cfg_ready` low until the boundary.
  - Boundary tick arrives after 3 more cycles with `div_active`=6.
  - Subsequent ticks are 6 cycles apart.
- Transfer `cfg_div`=1 in RUN:
  - `cfg_err` pulses one cycle.
  - `div_active` stays 4, tick spacing unchanged, `cfg_ready` stays 1.
- In PEND (pending 7), drop `run`:
  - STOP with `div_active`=7, prescaler 0, no tick.
  - `run`=1 gives the first tick 7 cycles later.
- Assert `rst` in PEND with `tick_1khz` high:
  - Next cycle all outputs at reset values: `div_active`=4, `cfg_ready`=1, ticks 0, `ms_count` 0.
